// File: rtl/dma_wr_beat_gen_if.sv
// dma_wr_beat_gen bus bundle: burst request, AXI AW/W/B, data buffer, status.
// master = the beat generator, slave = surrounding DMA / interconnect.
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

interface dma_wr_beat_gen_if #(
  parameter int MAX_OUTST = 4
);
  localparam int AW = `DMA_ADDR_WIDTH;
  localparam int SW = `DMA_DATA_WIDTH / 8;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  logic                       dma_abort_i;
  logic                       req_valid_i;
  logic                       req_ready_o;
  logic [AW-1:0]              req_addr_i;
  logic [7:0]                 req_alen_i;
  logic [2:0]                 req_size_i;
  logic [SW-1:0]              req_strb_i;
  logic                       req_fixed_i;
  logic                       awvalid_o;
  logic                       awready_i;
  logic [AW-1:0]              awaddr_o;
  logic [7:0]                 awlen_o;
  logic [2:0]                 awsize_o;
  logic [1:0]                 awburst_o;
  logic                       buf_valid_i;
  logic                       buf_ready_o;
  logic [`DMA_DATA_WIDTH-1:0] buf_data_i;
  logic                       wvalid_o;
  logic                       wready_i;
  logic [`DMA_DATA_WIDTH-1:0] wdata_o;
  logic [SW-1:0]              wstrb_o;
  logic                       wlast_o;
  logic                       bvalid_i;
  logic                       bready_o;
  logic [1:0]                 bresp_i;
  logic [OW-1:0]              outst_o;
  logic                       idle_o;
  logic                       err_o;

  modport master (
    input  dma_abort_i,
    input  req_valid_i,
    output req_ready_o,
    input  req_addr_i,
    input  req_alen_i,
    input  req_size_i,
    input  req_strb_i,
    input  req_fixed_i,
    output awvalid_o,
    input  awready_i,
    output awaddr_o,
    output awlen_o,
    output awsize_o,
    output awburst_o,
    input  buf_valid_i,
    output buf_ready_o,
    input  buf_data_i,
    output wvalid_o,
    input  wready_i,
    output wdata_o,
    output wstrb_o,
    output wlast_o,
    input  bvalid_i,
    output bready_o,
    input  bresp_i,
    output outst_o,
    output idle_o,
    output err_o
  );

  modport slave (
    output dma_abort_i,
    output req_valid_i,
    input  req_ready_o,
    output req_addr_i,
    output req_alen_i,
    output req_size_i,
    output req_strb_i,
    output req_fixed_i,
    input  awvalid_o,
    output awready_i,
    input  awaddr_o,
    input  awlen_o,
    input  awsize_o,
    input  awburst_o,
    output buf_valid_i,
    input  buf_ready_o,
    output buf_data_i,
    input  wvalid_o,
    output wready_i,
    input  wdata_o,
    input  wstrb_o,
    input  wlast_o,
    output bvalid_i,
    input  bready_o,
    output bresp_i,
    input  outst_o,
    input  idle_o,
    input  err_o
  );
endinterface

// File: rtl/dma_wr_beat_gen.sv
// Write-side AXI issue stage: AW issue, W beat generation, B retirement.
// Optional sticky BRESP error flag enabled by defining DMA_WR_ERR_EN.
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

module dma_wr_beat_gen #(
  parameter int MAX_OUTST = 4
) (
  input logic               clk,
  input logic               rst,
  dma_wr_beat_gen_if.master bus
);
  localparam int AW = `DMA_ADDR_WIDTH;
  localparam int SW = `DMA_DATA_WIDTH / 8;
  localparam int PW = $clog2(MAX_OUTST);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  typedef struct packed {
    logic [7:0]    alen;
    logic [SW-1:0] strb;
  } txn_t;

  txn_t          fifo_mem [MAX_OUTST];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  txn_t          head;

  logic          aw_pend;
  logic [AW-1:0] aw_addr;
  logic [7:0]    aw_len;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;

  logic [7:0]    beat_cnt;
  logic [OW-1:0] outst;
  logic [OW:0]   inflight;
  logic          room;

  logic          req_acc;
  logic          aw_hs;
  logic          w_hs;
  logic          w_last;
  logic          w_done;
  logic          b_take;
  logic          idle;
  logic          inc;
  logic          dec;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head       = fifo_mem[rd_ptr[PW-1:0]];

  // A latched AW counts against the limit before its handshake.
  assign inflight = {1'b0, outst} + {{OW{1'b0}}, aw_pend};
  assign room     = inflight < {1'b0, OUTST_MAX};

  assign aw_hs   = aw_pend & bus.awready_i;
  assign req_acc = bus.req_valid_i & bus.req_ready_o;

  assign bus.req_ready_o = rst & ~bus.dma_abort_i &
                           (~aw_pend | aw_hs) &
                           ~fifo_full & room;

  assign bus.awvalid_o = aw_pend;
  assign bus.awaddr_o  = aw_addr;
  assign bus.awlen_o   = aw_len;
  assign bus.awsize_o  = aw_size;
  assign bus.awburst_o = aw_burst;

  assign w_last = ~fifo_empty & (beat_cnt == head.alen);
  assign w_hs   = bus.wvalid_o & bus.wready_i;
  assign w_done = w_hs & w_last;

  assign bus.wvalid_o    = ~fifo_empty & bus.buf_valid_i;
  assign bus.buf_ready_o = ~fifo_empty & bus.wready_i;
  assign bus.wdata_o     = bus.buf_data_i;
  assign bus.wstrb_o     = fifo_empty ? '0 : head.strb;
  assign bus.wlast_o     = w_last;

  assign bus.bready_o = 1'b1;
  assign b_take       = bus.bvalid_i & (outst != '0);

  assign inc = aw_hs & ~b_take & (outst != OUTST_MAX);
  assign dec = b_take & ~aw_hs;

  assign idle        = ~aw_pend & fifo_empty & (outst == '0);
  assign bus.idle_o  = idle;
  assign bus.outst_o = outst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_pend  <= 1'b0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
    end else if (req_acc) begin
      aw_pend  <= 1'b1;
      aw_addr  <= bus.req_addr_i;
      aw_len   <= bus.req_alen_i;
      aw_size  <= bus.req_size_i;
      aw_burst <= bus.req_fixed_i ? 2'b00 : 2'b01;
    end else if (aw_hs) begin
      aw_pend  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (req_acc) begin
      fifo_mem[wr_ptr[PW-1:0]] <= '{
        alen: bus.req_alen_i,
        strb: bus.req_strb_i
      };
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (req_acc) wr_ptr <= wr_ptr + 1'b1;
      if (w_done)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (w_hs) begin
      beat_cnt <= w_last ? 8'd0 : beat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst <= '0;
    end else begin
      unique case (1'b1)
        inc:     outst <= outst + 1'b1;
        dec:     outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

`ifdef DMA_WR_ERR_EN
  logic err_q;

  // Error set wins over a same-cycle restart clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (bus.bvalid_i && bus.bresp_i[1]) begin
      err_q <= 1'b1;
    end else if (req_acc && idle) begin
      err_q <= 1'b0;
    end
  end

  assign bus.err_o = err_q;
`else
  logic unused_bresp;

  assign unused_bresp = ^bus.bresp_i;
  assign bus.err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dma_wr_beat_gen.sv
// Self-checking bench for dma_wr_beat_gen: vector table, directed corners,
// and randomized traffic against a queue-based transaction model.
`ifndef DMA_ADDR_WIDTH
`define DMA_ADDR_WIDTH 32
`endif
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 64
`endif

module tb_dma_wr_beat_gen;
  localparam int MO = 4;
  localparam int AW = `DMA_ADDR_WIDTH;
  localparam int SW = `DMA_DATA_WIDTH / 8;
`ifdef DMA_WR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #10 clk = ~clk;

  dma_wr_beat_gen_if #(.MAX_OUTST(MO)) bus ();

  dma_wr_beat_gen #(.MAX_OUTST(MO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } aw_t;

  typedef struct packed {
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  aw_t   aw_q[$];
  beat_t beat_q[$];
  int    m_outst = 0;
  bit    m_err = 1'b0;
  int    m_acc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    bus.dma_abort_i = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_alen_i  = '0;
    bus.req_size_i  = '0;
    bus.req_strb_i  = '0;
    bus.req_fixed_i = 1'b0;
    bus.awready_i   = 1'b0;
    bus.buf_valid_i = 1'b0;
    bus.buf_data_i  = '0;
    bus.wready_i    = 1'b0;
    bus.bvalid_i    = 1'b0;
    bus.bresp_i     = 2'b00;
  endtask

  task automatic set_req(logic [AW-1:0] a, logic [7:0] l,
                         logic [2:0] s, logic [SW-1:0] st, logic f);
    bus.req_addr_i  = a;
    bus.req_alen_i  = l;
    bus.req_size_i  = s;
    bus.req_strb_i  = st;
    bus.req_fixed_i = f;
  endtask

  task automatic model_reset();
    aw_q.delete();
    beat_q.delete();
    m_outst = 0;
    m_err   = 1'b0;
  endtask

  // One clock: compare DUT against the model, then advance the model.
  task automatic cyc();
    bit    rr, awh, wh, bh, midle;
    int    occ;
    aw_t   a;
    beat_t bt;
    #1;
    occ = 0;
    foreach (beat_q[i]) if (beat_q[i].last) occ++;
    awh   = rst && aw_q.size() != 0 && bus.awready_i;
    rr    = rst && !bus.dma_abort_i && (aw_q.size() == 0 || awh) &&
            occ < MO && (m_outst + aw_q.size()) < MO;
    midle = aw_q.size() == 0 && beat_q.size() == 0 && m_outst == 0;
    chk("req_ready", bus.req_ready_o, rr);
    chk("awvalid", bus.awvalid_o, aw_q.size() != 0);
    if (aw_q.size() != 0) begin
      a = aw_q[0];
      chk("awaddr", bus.awaddr_o, a.addr);
      chk("awlen", bus.awlen_o, a.len);
      chk("awsize", bus.awsize_o, a.size);
      chk("awburst", bus.awburst_o, a.burst);
    end
    chk("wvalid", bus.wvalid_o, beat_q.size() != 0 && bus.buf_valid_i);
    chk("buf_ready", bus.buf_ready_o, beat_q.size() != 0 && bus.wready_i);
    if (beat_q.size() != 0) begin
      bt = beat_q[0];
      chk("wstrb", bus.wstrb_o, bt.strb);
      chk("wlast", bus.wlast_o, bt.last);
      chk("wdata", bus.wdata_o, bus.buf_data_i);
    end else begin
      chk("wlast_empty", bus.wlast_o, 0);
    end
    chk("outst", bus.outst_o, m_outst);
    chk("idle", bus.idle_o, midle);
    chk("err", bus.err_o, m_err);
    chk("bready", bus.bready_o, 1);
    wh = beat_q.size() != 0 && bus.buf_valid_i && bus.wready_i;
    bh = rst && bus.bvalid_i;
    if (ERR_EN) begin
      if (rr && bus.req_valid_i && midle) m_err = 1'b0;
      if (bh && bus.bresp_i[1]) m_err = 1'b1;
    end
    if (bh && m_outst > 0 && !awh) m_outst--;
    else if (awh && !(bh && m_outst > 0)) m_outst++;
    if (awh) void'(aw_q.pop_front());
    if (wh) void'(beat_q.pop_front());
    if (rr && bus.req_valid_i) begin
      aw_q.push_back('{addr: bus.req_addr_i, len: bus.req_alen_i,
                       size: bus.req_size_i,
                       burst: bus.req_fixed_i ? 2'b00 : 2'b01});
      for (int k = 0; k <= int'(bus.req_alen_i); k++)
        beat_q.push_back('{strb: bus.req_strb_i,
                           last: (k == int'(bus.req_alen_i))});
      m_acc++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    bus.req_valid_i = 1'b0;
    bus.awready_i   = 1'b1;
    bus.buf_valid_i = 1'b1;
    bus.wready_i    = 1'b1;
    bus.bresp_i     = 2'b00;
    for (int i = 0; i < 60; i++) begin
      if (aw_q.size() == 0 && beat_q.size() == 0 && m_outst == 0) break;
      bus.bvalid_i = (m_outst > 0);
      cyc();
    end
    bus.bvalid_i = 1'b0;
    chk("drain_idle", bus.idle_o, 1);
  endtask

  typedef struct {
    bit rv, awr, bfv, wr, bvl;
    bit rr, awv, wv, wl;
    int os;
    bit idl;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1};

    clear_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    bus.req_valid_i = 1'b1;
    bus.buf_valid_i = 1'b1;
    #1;
    chk("rst_req_ready", bus.req_ready_o, 0);
    chk("rst_awvalid", bus.awvalid_o, 0);
    chk("rst_wvalid", bus.wvalid_o, 0);
    chk("rst_wlast", bus.wlast_o, 0);
    chk("rst_outst", bus.outst_o, 0);
    chk("rst_idle", bus.idle_o, 1);
    chk("rst_err", bus.err_o, 0);
    chk("rst_bready", bus.bready_o, 1);
    chk("rst_awaddr", bus.awaddr_o, 0);
    chk("rst_awlen", bus.awlen_o, 0);
    chk("rst_awsize", bus.awsize_o, 0);
    chk("rst_awburst", bus.awburst_o, 0);
    clear_in();
    rst = 1'b1;
    @(posedge clk);
    #2;

    // single INCR burst, vector table
    set_req(32'h1000, 8'd3, 3'd3, 8'hFF, 1'b0);
    bus.buf_data_i = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 7; i++) begin
      bus.req_valid_i = tbl[i].rv;
      bus.awready_i   = tbl[i].awr;
      bus.buf_valid_i = tbl[i].bfv;
      bus.wready_i    = tbl[i].wr;
      bus.bvalid_i    = tbl[i].bvl;
      #1;
      chk($sformatf("tv%0d_req_ready", i), bus.req_ready_o, tbl[i].rr);
      chk($sformatf("tv%0d_awvalid", i), bus.awvalid_o, tbl[i].awv);
      chk($sformatf("tv%0d_wvalid", i), bus.wvalid_o, tbl[i].wv);
      chk($sformatf("tv%0d_wlast", i), bus.wlast_o, tbl[i].wl);
      chk($sformatf("tv%0d_outst", i), bus.outst_o, tbl[i].os);
      chk($sformatf("tv%0d_idle", i), bus.idle_o, tbl[i].idl);
      if (tbl[i].awv) begin
        chk("tv_awaddr", bus.awaddr_o, 32'h1000);
        chk("tv_awlen", bus.awlen_o, 3);
        chk("tv_awburst", bus.awburst_o, 2'b01);
      end
      if (tbl[i].wv) chk("tv_wstrb", bus.wstrb_o, 8'hFF);
      @(posedge clk);
      #2;
    end
    clear_in();

    // single beat with partial strobe
    set_req(32'h1100, 8'd0, 3'd3, 8'hF0, 1'b0);
    bus.req_valid_i = 1'b1;
    cyc();
    bus.req_valid_i = 1'b0;
    bus.awready_i   = 1'b1;
    bus.buf_valid_i = 1'b1;
    bus.wready_i    = 1'b1;
    bus.buf_data_i  = 64'h0BAD_F00D_CAFE_0001;
    #1;
    chk("ub_wvalid", bus.wvalid_o, 1);
    chk("ub_wstrb", bus.wstrb_o, 8'hF0);
    chk("ub_wlast", bus.wlast_o, 1);
    cyc();
    drain();

    // AW backpressure while W completes first
    clear_in();
    set_req(32'h2000, 8'd1, 3'd2, 8'h0F, 1'b1);
    bus.req_valid_i = 1'b1;
    cyc();
    bus.req_valid_i = 1'b0;
    bus.buf_valid_i = 1'b1;
    bus.wready_i    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.buf_data_i = {$urandom, $urandom};
      cyc();
    end
    #1;
    chk("bp_awvalid", bus.awvalid_o, 1);
    chk("bp_awaddr", bus.awaddr_o, 32'h2000);
    chk("bp_awburst", bus.awburst_o, 2'b00);
    chk("bp_w_popped", bus.wvalid_o, 0);
    drain();

    // outstanding limit with B withheld
    clear_in();
    set_req(32'h3000, 8'd0, 3'd3, 8'h3C, 1'b0);
    bus.req_valid_i = 1'b1;
    bus.awready_i   = 1'b1;
    bus.buf_valid_i = 1'b1;
    bus.wready_i    = 1'b1;
    m_acc = 0;
    for (int i = 0; i < 6; i++) cyc();
    #1;
    chk("lim_req_ready", bus.req_ready_o, 0);
    chk("lim_outst", bus.outst_o, MO);
    bus.bvalid_i = 1'b1;
    cyc();
    bus.bvalid_i = 1'b0;
    #1;
    chk("lim_reopen", bus.req_ready_o, 1);
    for (int i = 0; i < 40 && m_acc < 6; i++) begin
      bus.bvalid_i = 1'($urandom % 2);
      cyc();
    end
    drain();

    // same-cycle AW and B at outst 2
    clear_in();
    set_req(32'h3800, 8'd0, 3'd3, 8'hFF, 1'b0);
    bus.buf_valid_i = 1'b1;
    bus.wready_i    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid_i = (i % 2 == 0);
      bus.awready_i   = (i % 2 == 1);
      bus.bvalid_i    = (i == 5);
      cyc();
    end
    bus.bvalid_i = 1'b0;
    bus.awready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    #1;
    chk("same_outst", bus.outst_o, 2);
    drain();

    // error response
    clear_in();
    set_req(32'h5000, 8'd0, 3'd3, 8'hFF, 1'b0);
    bus.req_valid_i = 1'b1;
    bus.awready_i   = 1'b1;
    bus.buf_valid_i = 1'b1;
    bus.wready_i    = 1'b1;
    cyc();
    bus.req_valid_i = 1'b0;
    cyc();
    bus.bvalid_i = 1'b1;
    bus.bresp_i  = 2'b10;
    cyc();
    bus.bvalid_i = 1'b0;
    bus.bresp_i  = 2'b00;
    #1;
    chk("err_set", bus.err_o, ERR_EN);
    cyc();
    chk("err_sticky", bus.err_o, ERR_EN);
    bus.req_valid_i = 1'b1;
    cyc();
    bus.req_valid_i = 1'b0;
    #1;
    chk("err_clear", bus.err_o, 0);
    drain();

    // abort with two queued bursts
    clear_in();
    set_req(32'h6000, 8'd1, 3'd3, 8'hAA, 1'b0);
    bus.req_valid_i = 1'b1;
    cyc();
    bus.awready_i = 1'b1;
    cyc();
    bus.dma_abort_i = 1'b1;
    #1;
    chk("abort_ready", bus.req_ready_o, 0);
    chk("abort_busy", bus.idle_o, 0);
    cyc();
    drain();
    bus.dma_abort_i = 1'b0;

    // reset in the middle of a burst
    clear_in();
    set_req(32'h7000, 8'd3, 3'd3, 8'hFF, 1'b0);
    bus.req_valid_i = 1'b1;
    cyc();
    bus.req_valid_i = 1'b0;
    bus.buf_valid_i = 1'b1;
    bus.wready_i    = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst_awvalid", bus.awvalid_o, 0);
    chk("mrst_wvalid", bus.wvalid_o, 0);
    chk("mrst_wlast", bus.wlast_o, 0);
    chk("mrst_outst", bus.outst_o, 0);
    chk("mrst_idle", bus.idle_o, 1);
    chk("mrst_ready", bus.req_ready_o, 0);
    model_reset();
    clear_in();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    cyc();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bus.req_valid_i = 1'($urandom % 2);
      bus.dma_abort_i = ($urandom % 20 == 0);
      set_req(AW'($urandom) & ~AW'(7), 8'($urandom_range(0, 3)),
              3'($urandom_range(0, 3)), SW'($urandom),
              1'($urandom % 2));
      bus.awready_i   = ($urandom % 10 < 6);
      bus.buf_valid_i = ($urandom % 10 < 7);
      bus.wready_i    = ($urandom % 10 < 7);
      bus.buf_data_i  = {$urandom, $urandom};
      bus.bvalid_i    = (m_outst > 0) ? ($urandom % 2 == 0)
                                      : ($urandom % 20 == 0);
      bus.bresp_i     = ($urandom % 10 == 0) ? 2'($urandom) : 2'b00;
      cyc();
    end
    clear_in();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_wr_beat_gen.md
# dma_wr_beat_gen

Write-side AXI issue stage sitting directly downstream of the write `dma_streamer` instance. It accepts burst requests (address, length, size, strobe, mode) and drives the AXI AW channel. It generates the matching W beats (WSTRB/WLAST) from the DMA data buffer and retires B responses. It tracks outstanding write transactions and reports idle/error status to the DMA FSM.

## Interface
Parameters:
- `MAX_OUTST`, 4: maximum outstanding write bursts (AW issued, B not yet received). Power of 2, range 2–16.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `dma_abort_i`  in  1  abort; blocks new requests
- `req_valid_i`  in  1  burst request valid
- `req_ready_o`  out  1  burst request accepted
- `req_addr_i`  in  `DMA_ADDR_WIDTH`  aligned burst address
- `req_alen_i`  in  8  AXI length (beats-1)
- `req_size_i`  in  3  AXI size
- `req_strb_i`  in  `DMA_DATA_WIDTH/8`  byte strobe applied to every beat
- `req_fixed_i`  in  1  1 = FIXED burst, 0 = INCR
- `awvalid_o` / `awready_i`  out/in  1  AW handshake
- `awaddr_o`  out  `DMA_ADDR_WIDTH`
- `awlen_o`  out  8
- `awsize_o`  out  3
- `awburst_o`  out  2  (00 FIXED, 01 INCR)
- `buf_valid_i` / `buf_ready_o`  in/out  1  data buffer handshake
- `buf_data_i`  in  `DMA_DATA_WIDTH`
- `wvalid_o` / `wready_i`  out/in  1  W handshake
- `wdata_o`  out  `DMA_DATA_WIDTH`
- `wstrb_o`  out  `DMA_DATA_WIDTH/8`
- `wlast_o`  out  1
- `bvalid_i`  in  1
- `bready_o`  out  1
- `bresp_i`  in  2
- `outst_o`  out  `$clog2(MAX_OUTST)+1`  outstanding burst count
- `idle_o`  out  1  no AW pending, no W pending, `outst_o == 0`
- `err_o`  out  1  sticky write error (see Configuration)

## Operation
- AW holding register: 1 entry. Loaded on `req_valid_i && req_ready_o`. Cleared on `awvalid_o && awready_i`.
- Txn FIFO: `MAX_OUTST` entries of {alen, strb}. Pushed on request accept. Popped on the W handshake with `wlast_o = 1`.
- `req_ready_o = ~dma_abort_i && (AW reg empty || AW handshake this cycle) && txn FIFO not full && (outst + AW-pending) < MAX_OUTST`.
- W engine:
  - `wvalid_o = FIFO non-empty && buf_valid_i`.
  - `buf_ready_o = FIFO non-empty && wready_i` (pass-through, no data register).
  - `wdata_o = buf_data_i`; `wstrb_o` = head strb.
  - Beat counter starts at 0 and increments per W handshake.
  - `wlast_o = (beat_cnt == head alen)`. On the last handshake, beat_cnt returns to 0.
- W may precede AW; AXI permits this.
- Outstanding counter:
  - +1 on AW handshake, -1 on B handshake, unchanged if both occur in the same cycle.
  - Never exceeds `MAX_OUTST` and never underflows.
  - A B handshake with `outst == 0` is ignored.
- `bready_o` is constantly 1.
- Abort: only new requests are blocked. Any AW already latched and all queued W beats complete, because AXI cannot drop in-flight bursts. `idle_o` asserts once drained.

## Timing
- Reset values:
  - `awvalid_o` 0, `wvalid_o` 0, `wlast_o` 0, `req_ready_o` 0 while in reset.
  - `outst_o` 0, `idle_o` 1, `err_o` 0, `bready_o` 1.
  - `awaddr_o`/`awlen_o`/`awsize_o`/`awburst_o` 0.
  - FIFO empty, beat_cnt 0.
- Request accepted in cycle N: `awvalid_o` is high from N+1, and the earliest `wvalid_o` is at N+1.
- AW fields stay stable while `awvalid_o && ~awready_i`.
- `wvalid_o` never deasserts without a handshake once `buf_valid_i` holds; the buffer must hold its data until `buf_ready_o`.
- Throughput: 1 request per cycle and 1 W beat per cycle.
- Reset asserted mid-burst: all state clears immediately. No W completion is attempted; the interconnect is reset together with this block.

## Configuration
- `DMA_WR_ERR_EN` defined:
  - `err_o` is set on a B handshake with `bresp_i` of SLVERR (10) or DECERR (11).
  - It clears only when `req_valid_i` is accepted while `idle_o = 1` (new transfer start).
- Not defined: `err_o` is tied to 0 and `bresp_i` is ignored; outstanding tracking is unchanged.

## Test plan
- Single INCR request: addr 0x1000, alen 3, strb 0xFF, B OKAY after last beat -> one AW (awlen 3, awburst 01), 4 W beats, `wlast_o` only on beat 4, `outst_o` goes 0→1→0, `idle_o` returns to 1.
- Unaligned single beat: alen 0, strb 0xF0 -> one W beat with `wstrb_o` 0xF0 and `wlast_o = 1`.
- Backpressure: hold `awready_i = 0` for 5 cycles while W completes -> AW fields stable, W beats accepted before AW, FIFO pop correct.
- Outstanding limit, `MAX_OUTST = 4`: 6 back-to-back alen-0 requests with B withheld -> `req_ready_o` drops after 4 AW handshakes and reasserts the cycle after the first B.
- Same-cycle AW and B handshakes with `outst_o = 2` -> remains 2.
- Error path: B with bresp 10 -> with `DMA_WR_ERR_EN`, `err_o = 1` sticky until the next idle start; without it, `err_o` stays 0.
- Abort with 2 queued bursts -> `req_ready_o = 0`, both bursts finish, `idle_o = 1` after the final B.
